// File: rtl/cpu_sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_sram_arb_pkg
// Brief   : Shared IDs, lock-state encoding and helpers for the IF/EXE
//           SRAM-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_sram_arb_pkg;

  // Requester IDs carried through the response FIFO
  localparam logic c_id_inst = 1'b0;
  localparam logic c_id_data = 1'b1;

  // Fetches are always full-word reads
  localparam logic [1:0] c_size_word = 2'b10;

  // Ownership lock held while an issued request waits for addr_ok
  typedef enum logic [1:0] {
    LOCK_NONE = 2'b00,
    LOCK_INST = 2'b01,
    LOCK_DATA = 2'b10
  } lock_state_t;

  // Lock state that pins ownership to the given requester
  function automatic lock_state_t lock_for(input logic id);
    return (id == c_id_data) ? LOCK_DATA : LOCK_INST;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sram_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : cpu_sram_arb_if
// Brief   : Fetch, data and bridge-side SRAM-like handshake signals.
//           slave  = arbiter view, master = pipeline/bridge view.
// Revision: 1.0 - initial release
// ============================================================================
interface cpu_sram_arb_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sram_arb_resp_id_fifo.sv
`default_nettype none
// ============================================================================
// Module  : resp_id_fifo
// Brief   : 1-bit circular FIFO of requester IDs, one entry per accepted
//           bus request, popped in order as responses return.
// Revision: 1.0 - initial release
// ============================================================================
module resp_id_fifo #(
  parameter int OUTSTANDING = 2,
  localparam int CNT_W = $clog2(OUTSTANDING) + 1,
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic             push_id,
  input  wire logic             pop,
  output logic                  head_id,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [OUTSTANDING-1:0] r_mem;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_push;
  logic                   w_pop;

  // Pointers wrap at OUTSTANDING, which need not fill the pointer width
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Overflow/underflow are blocked here so callers cannot corrupt the count
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign full    = (r_count == CNT_W'(OUTSTANDING));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign head_id = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; simultaneous push+pop keeps the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_id;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_sram_arb.sv
`default_nettype none
// ============================================================================
// Module  : cpu_sram_arb
// Brief   : Shares one SRAM-like port between instruction fetch and data
//           access. Data has fixed priority, ownership is locked while an
//           issued request waits for addr_ok, and responses are steered
//           back in order through a requester-ID FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_sram_arb
  import cpu_sram_arb_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input wire logic       clk,
  input wire logic       reset,
  cpu_sram_arb_if.slave  sram
);

  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  lock_state_t      r_lock;
  logic             w_owner_valid;
  logic             w_owner_id;
  logic             w_owner_req;
  logic             w_bus_req;
  logic             w_accept;
  logic             w_resp;
  logic             w_full;
  logic             w_empty;
  logic             w_head_id;
  logic [CNT_W-1:0] w_count;

  // Grant: a held lock wins, otherwise data beats fetch
  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_id    = c_id_inst;
    case (r_lock)
      LOCK_INST: begin
        w_owner_valid = 1'b1;
        w_owner_id    = c_id_inst;
      end
      LOCK_DATA: begin
        w_owner_valid = 1'b1;
        w_owner_id    = c_id_data;
      end
      default: begin
        if (sram.data_req) begin
          w_owner_valid = 1'b1;
          w_owner_id    = c_id_data;
        end else if (sram.inst_req) begin
          w_owner_valid = 1'b1;
          w_owner_id    = c_id_inst;
        end
      end
    endcase
  end

  // Full gating uses only registered occupancy, so data_ok never reaches req
  assign w_owner_req = (w_owner_id == c_id_data) ? sram.data_req : sram.inst_req;
  assign w_bus_req   = ~reset & w_owner_valid & w_owner_req & ~w_full;
  assign w_accept    = w_bus_req & sram.bus_addr_ok;

  assign sram.bus_req      = w_bus_req;
  assign sram.inst_addr_ok = w_accept & (w_owner_id == c_id_inst);
  assign sram.data_addr_ok = w_accept & (w_owner_id == c_id_data);

  // Request field mux; fetches are forced to word reads, all zero in reset
  always_comb begin
    sram.bus_wr    = 1'b0;
    sram.bus_size  = 2'b00;
    sram.bus_wstrb = 4'h0;
    sram.bus_addr  = 32'h0;
    sram.bus_wdata = 32'h0;
    if (!reset && w_owner_valid) begin
      if (w_owner_id == c_id_data) begin
        sram.bus_wr    = sram.data_wr;
        sram.bus_size  = sram.data_size;
        sram.bus_wstrb = sram.data_wstrb;
        sram.bus_addr  = sram.data_addr;
        sram.bus_wdata = sram.data_wdata;
      end else begin
        sram.bus_size  = c_size_word;
        sram.bus_addr  = sram.inst_addr;
      end
    end
  end

  // Lock on a stalled request, release on its acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock <= LOCK_NONE;
    end else begin
      case (r_lock)
        LOCK_NONE: begin
          if (w_bus_req && !sram.bus_addr_ok) begin
            r_lock <= lock_for(w_owner_id);
          end
        end
        default: begin
          if (w_accept) begin
            r_lock <= LOCK_NONE;
          end
        end
      endcase
    end
  end

  // Stray data_ok with nothing outstanding is dropped by the count check
  resp_id_fifo #(
    .OUTSTANDING (OUTSTANDING)
  ) u_resp_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_accept),
    .push_id (w_owner_id),
    .pop     (sram.bus_data_ok & (w_count != '0)),
    .head_id (w_head_id),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_resp            = ~reset & sram.bus_data_ok & ~w_empty;
  assign sram.inst_data_ok = w_resp & (w_head_id == c_id_inst);
  assign sram.data_data_ok = w_resp & (w_head_id == c_id_data);
  assign sram.inst_rdata   = sram.bus_rdata;
  assign sram.data_rdata   = sram.bus_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sram_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_sram_arb
// Brief   : Directed self-checking bench for cpu_sram_arb (OUTSTANDING=2).
//           Inputs change 1 ns after a rising edge; outputs are sampled on
//           the falling edge, so "cycle N" ends at the next rising edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_sram_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  cpu_sram_arb_if bif ();

  cpu_sram_arb #(
    .OUTSTANDING (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sram  (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bif.inst_req    = 1'b0;
    bif.inst_addr   = 32'h0;
    bif.data_req    = 1'b0;
    bif.data_wr     = 1'b0;
    bif.data_size   = 2'b00;
    bif.data_wstrb  = 4'h0;
    bif.data_addr   = 32'h0;
    bif.data_wdata  = 32'h0;
    bif.bus_addr_ok = 1'b0;
    bif.bus_data_ok = 1'b0;
    bif.bus_rdata   = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    bif.inst_req = 1'b1; bif.inst_addr = 32'h1c00_0000;
    bif.data_req = 1'b1; bif.data_wr = 1'b1; bif.data_size = 2'b10;
    bif.data_wstrb = 4'hf; bif.data_addr = 32'h44; bif.data_wdata = 32'h1111_2222;
    bif.bus_addr_ok = 1'b1; bif.bus_data_ok = 1'b1;
    smp();
    total++; if (bif.bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req: got %b want 0", bif.bus_req); end
    total++; if ({bif.inst_addr_ok, bif.data_addr_ok} !== 2'b00) begin bad++; $display("FAIL rst_addr_ok: got %b want 00", {bif.inst_addr_ok, bif.data_addr_ok}); end
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b00) begin bad++; $display("FAIL rst_data_ok: got %b want 00", {bif.inst_data_ok, bif.data_data_ok}); end
    total++; if ({bif.bus_wr, bif.bus_size, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata} !== 71'h0) begin bad++; $display("FAIL rst_bus_fields: got %h want 0", {bif.bus_wr, bif.bus_size, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata}); end
    idle();
    @(posedge clk);
    #3 reset = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    // cycle 0: fetch accepted immediately
    bif.inst_req = 1'b1; bif.inst_addr = 32'h1c00_0000; bif.bus_addr_ok = 1'b1;
    smp();
    total++; if (bif.inst_addr_ok !== 1'b1) begin bad++; $display("FAIL fetch_addr_ok: got %b want 1", bif.inst_addr_ok); end
    total++; if ({bif.bus_req, bif.bus_wr, bif.bus_size, bif.bus_wstrb} !== 8'b1_0_10_0000) begin bad++; $display("FAIL fetch_bus_ctl: got %b want 10100000", {bif.bus_req, bif.bus_wr, bif.bus_size, bif.bus_wstrb}); end
    total++; if (bif.bus_addr !== 32'h1c00_0000) begin bad++; $display("FAIL fetch_bus_addr: got %h want 1c000000", bif.bus_addr); end
    step();
    // cycle 1: waiting
    idle();
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok, bif.bus_req} !== 3'b000) begin bad++; $display("FAIL fetch_wait: got %b want 000", {bif.inst_data_ok, bif.data_data_ok, bif.bus_req}); end
    step();
    // cycle 2: response
    bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h1234_5678;
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b10) begin bad++; $display("FAIL fetch_data_ok: got %b want 10", {bif.inst_data_ok, bif.data_data_ok}); end
    total++; if (bif.inst_rdata !== 32'h1234_5678) begin bad++; $display("FAIL fetch_rdata: got %h want 12345678", bif.inst_rdata); end
    step();
    idle();
  endtask

  task automatic test_priority();
    // cycle 0: both request, data wins
    bif.inst_req = 1'b1; bif.inst_addr = 32'h1c00_0004;
    bif.data_req = 1'b1; bif.data_addr = 32'h80; bif.bus_addr_ok = 1'b1;
    smp();
    total++; if (bif.bus_addr !== 32'h80) begin bad++; $display("FAIL prio_bus_addr: got %h want 00000080", bif.bus_addr); end
    total++; if ({bif.data_addr_ok, bif.inst_addr_ok} !== 2'b10) begin bad++; $display("FAIL prio_addr_ok: got %b want 10", {bif.data_addr_ok, bif.inst_addr_ok}); end
    step();
    // cycle 1: fetch granted once data drops
    bif.data_req = 1'b0;
    smp();
    total++; if ({bif.inst_addr_ok, bif.bus_addr} !== {1'b1, 32'h1c00_0004}) begin bad++; $display("FAIL prio_inst_next: got %b/%h want 1/1c000004", bif.inst_addr_ok, bif.bus_addr); end
    step();
    // responses come back data first, then fetch
    idle(); bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'haaaa_0001;
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b01) begin bad++; $display("FAIL prio_resp1: got %b want 01", {bif.inst_data_ok, bif.data_data_ok}); end
    total++; if (bif.data_rdata !== 32'haaaa_0001) begin bad++; $display("FAIL prio_rdata1: got %h want aaaa0001", bif.data_rdata); end
    step();
    bif.bus_rdata = 32'haaaa_0002;
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b10) begin bad++; $display("FAIL prio_resp2: got %b want 10", {bif.inst_data_ok, bif.data_data_ok}); end
    step();
    idle();
  endtask

  task automatic test_lock();
    bif.inst_req = 1'b1; bif.inst_addr = 32'h1c00_0100;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin bif.data_req = 1'b1; bif.data_addr = 32'h200; end
      if (c == 3) bif.bus_addr_ok = 1'b1;
      smp();
      total++; if (bif.bus_addr !== 32'h1c00_0100) begin bad++; $display("FAIL lock_bus_addr c%0d: got %h want 1c000100", c, bif.bus_addr); end
      total++; if ({bif.inst_addr_ok, bif.data_addr_ok} !== ((c == 3) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL lock_addr_ok c%0d: got %b want %b", c, {bif.inst_addr_ok, bif.data_addr_ok}, (c == 3) ? 2'b10 : 2'b00); end
      step();
    end
    // cycle 4: lock released, data granted
    bif.inst_req = 1'b0;
    smp();
    total++; if ({bif.data_addr_ok, bif.bus_addr} !== {1'b1, 32'h200}) begin bad++; $display("FAIL lock_data_next: got %b/%h want 1/00000200", bif.data_addr_ok, bif.bus_addr); end
    step();
    idle(); bif.bus_data_ok = 1'b1;
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b10) begin bad++; $display("FAIL lock_resp1: got %b want 10", {bif.inst_data_ok, bif.data_data_ok}); end
    step();
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b01) begin bad++; $display("FAIL lock_resp2: got %b want 01", {bif.inst_data_ok, bif.data_data_ok}); end
    step();
    idle();
  endtask

  task automatic test_full();
    bif.bus_addr_ok = 1'b1;
    bif.inst_req = 1'b1; bif.inst_addr = 32'h1c00_0200;
    step();
    bif.inst_req = 1'b0; bif.data_req = 1'b1; bif.data_addr = 32'h300;
    smp();
    total++; if (bif.data_addr_ok !== 1'b1) begin bad++; $display("FAIL full_second_accept: got %b want 1", bif.data_addr_ok); end
    step();
    // third request stalls while two are outstanding
    bif.data_req = 1'b0; bif.inst_req = 1'b1; bif.inst_addr = 32'h1c00_0204;
    for (int c = 0; c < 2; c++) begin
      smp();
      total++; if ({bif.bus_req, bif.inst_addr_ok} !== 2'b00) begin bad++; $display("FAIL full_stall c%0d: got %b want 00", c, {bif.bus_req, bif.inst_addr_ok}); end
      step();
    end
    // first response pops but the stall holds this cycle
    bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'hbbbb_0001;
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b10) begin bad++; $display("FAIL full_resp1: got %b want 10", {bif.inst_data_ok, bif.data_data_ok}); end
    total++; if ({bif.bus_req, bif.inst_addr_ok} !== 2'b00) begin bad++; $display("FAIL full_gate_same_cycle: got %b want 00", {bif.bus_req, bif.inst_addr_ok}); end
    step();
    // re-accept the cycle after the popping response
    bif.bus_data_ok = 1'b0;
    smp();
    total++; if ({bif.bus_req, bif.inst_addr_ok} !== 2'b11) begin bad++; $display("FAIL full_reaccept: got %b want 11", {bif.bus_req, bif.inst_addr_ok}); end
    step();
    idle(); bif.bus_data_ok = 1'b1;
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b01) begin bad++; $display("FAIL full_resp2: got %b want 01", {bif.inst_data_ok, bif.data_data_ok}); end
    step();
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b10) begin bad++; $display("FAIL full_resp3: got %b want 10", {bif.inst_data_ok, bif.data_data_ok}); end
    step();
    idle();
  endtask

  task automatic test_write();
    bif.data_req = 1'b1; bif.data_wr = 1'b1; bif.data_size = 2'b10;
    bif.data_wstrb = 4'hf; bif.data_addr = 32'h400; bif.data_wdata = 32'hdead_beef;
    bif.bus_addr_ok = 1'b1;
    smp();
    total++; if ({bif.bus_req, bif.bus_wr, bif.bus_size, bif.bus_wstrb} !== 8'b1_1_10_1111) begin bad++; $display("FAIL wr_bus_ctl: got %b want 11101111", {bif.bus_req, bif.bus_wr, bif.bus_size, bif.bus_wstrb}); end
    total++; if ({bif.bus_addr, bif.bus_wdata} !== {32'h400, 32'hdead_beef}) begin bad++; $display("FAIL wr_bus_data: got %h/%h want 00000400/deadbeef", bif.bus_addr, bif.bus_wdata); end
    step();
    idle(); bif.bus_data_ok = 1'b1;
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b01) begin bad++; $display("FAIL wr_resp: got %b want 01", {bif.inst_data_ok, bif.data_data_ok}); end
    step();
    idle();
  endtask

  task automatic test_async_reset();
    bif.bus_addr_ok = 1'b1;
    bif.inst_req = 1'b1; bif.inst_addr = 32'h1c00_0300;
    step();
    bif.inst_req = 1'b0; bif.data_req = 1'b1; bif.data_addr = 32'h500;
    step();
    // two outstanding; a third request and a response are pending
    bif.data_req = 1'b0; bif.inst_req = 1'b1; bif.inst_addr = 32'h1c00_0400;
    bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h55;
    #2 reset = 1'b1;
    #1;
    total++; if ({bif.bus_req, bif.inst_addr_ok, bif.data_addr_ok, bif.inst_data_ok, bif.data_data_ok} !== 5'b0) begin bad++; $display("FAIL arst_handshake: got %b want 00000", {bif.bus_req, bif.inst_addr_ok, bif.data_addr_ok, bif.inst_data_ok, bif.data_data_ok}); end
    total++; if ({bif.bus_wr, bif.bus_size, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata} !== 71'h0) begin bad++; $display("FAIL arst_bus_fields: got %h want 0", {bif.bus_wr, bif.bus_size, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata}); end
    bif.inst_req = 1'b0; bif.bus_addr_ok = 1'b0;
    #2 reset = 1'b0;
    #1;
    // stray response after reset: nothing outstanding
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b00) begin bad++; $display("FAIL arst_stray: got %b want 00", {bif.inst_data_ok, bif.data_data_ok}); end
    step();
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok} !== 2'b00) begin bad++; $display("FAIL arst_stray_edge: got %b want 00", {bif.inst_data_ok, bif.data_data_ok}); end
    step();
    // fresh fetch completes normally
    idle(); bif.inst_req = 1'b1; bif.inst_addr = 32'h1c00_0500; bif.bus_addr_ok = 1'b1;
    smp();
    total++; if ({bif.bus_req, bif.inst_addr_ok} !== 2'b11) begin bad++; $display("FAIL arst_refetch: got %b want 11", {bif.bus_req, bif.inst_addr_ok}); end
    step();
    idle(); bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'hcafe_f00d;
    smp();
    total++; if ({bif.inst_data_ok, bif.data_data_ok, bif.inst_rdata} !== {2'b10, 32'hcafe_f00d}) begin bad++; $display("FAIL arst_refetch_resp: got %b%b/%h want 10/cafef00d", bif.inst_data_ok, bif.data_data_ok, bif.inst_rdata); end
    step();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_fetch();
    test_priority();
    test_lock();
    test_full();
    test_write();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_sram_arb.md
# cpu_sram_arb

Two-master arbiter that shares the single SRAM-like memory port between the instruction-fetch side (IF, read-only) and the data side (EXE load/store) of the five-stage core. Fixed priority to data, ownership locked while an issued request awaits `addr_ok`, and an in-order response-ID FIFO that steers each `data_ok`/`rdata` back to the requester. Sits between the pipeline stages and the AXI bridge.

## Interface
- `OUTSTANDING`, 2: maximum accepted-but-unanswered bus requests; power of two, ≥1.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `inst_req` in 1 / `inst_addr` in 32: fetch request; always a word read.
- `inst_addr_ok` out 1 / `inst_data_ok` out 1 / `inst_rdata` out 32: fetch handshake and return data.
- `data_req` in 1 / `data_wr` in 1 / `data_size` in 2 / `data_wstrb` in 4 / `data_addr` in 32 / `data_wdata` in 32: data request.
- `data_addr_ok` out 1 / `data_data_ok` out 1 / `data_rdata` out 32: data handshake and return data.
- `bus_req` out 1 / `bus_wr` out 1 / `bus_size` out 2 / `bus_wstrb` out 4 / `bus_addr` out 32 / `bus_wdata` out 32: request to bridge.
- `bus_addr_ok` in 1 / `bus_data_ok` in 1 / `bus_rdata` in 32: bridge handshake and return data; responses in request order.

## Operation
- Handshake: a request is accepted on a cycle with `bus_req & bus_addr_ok`; a response completes on a cycle with `bus_data_ok`.
- Grant, combinational each cycle:
  - `lock` set: owner = `lock_id`.
  - Otherwise `data_req`: DATA.
  - Otherwise `inst_req`: INST.
  - Otherwise none.
- Lock register (states UNLOCKED / LOCK_INST / LOCK_DATA):
  - UNLOCKED → LOCK_x when owner x drives `bus_req` and `bus_addr_ok`=0.
  - LOCK_x → UNLOCKED on acceptance.
  - While locked, the other master is not granted even if higher priority.
- Mux: `bus_*` follow the owner's fields.
  - INST owner: `bus_wr`=0, `bus_size`=2'b10, `bus_wstrb`=4'h0, `bus_wdata`=0.
  - No owner: `bus_req`=0.
- Full gating: `full` = (count == `OUTSTANDING`). When `full`, `bus_req`=0 and both `*_addr_ok`=0, regardless of a same-cycle `bus_data_ok`. This avoids a comb path from `data_ok` to `req`.
- `x_addr_ok` = `bus_addr_ok & owner==x & ~full`.
- FIFO:
  - Push owner ID on acceptance; pop on `bus_data_ok` when count>0.
  - Simultaneous push and pop: count unchanged, head advances.
- Response steering:
  - `x_data_ok` = `bus_data_ok & count>0 & head==x`.
  - `inst_rdata` = `data_rdata` = `bus_rdata`, unconditionally.
  - Writes also receive `data_data_ok`.
- Stray `bus_data_ok` with count==0: ignored. No pop, no master `data_ok`, count stays 0.
- Pointers wrap modulo `OUTSTANDING`; count is `$clog2(OUTSTANDING)+1` bits.

## Timing
- Zero-cycle paths:
  - `*_req` → `bus_req`.
  - `bus_addr_ok` → `*_addr_ok`.
  - `bus_data_ok` → `*_data_ok`.
- No added latency beyond the bridge.
- Masters hold request fields stable from `req` until `addr_ok`. A master that drops `req` before acceptance while locked is a protocol violation; its behaviour is unspecified.
- Reset (asynchronous): count, pointers and lock clear immediately.
  - While `reset`=1: `bus_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok` all 0.
  - While `reset`=1: `bus_wr`=0, `bus_size`=0, `bus_wstrb`=0, `bus_addr`=0, `bus_wdata`=0.
  - Responses outstanding at reset are discarded; the bridge is reset on the same signal.
- Earliest re-accept after a full stall: the cycle after the popping `bus_data_ok`.

## Structure
- `mycpu.h` additions:
  - `` `ARB_ID_INST `` = 1'b0, `` `ARB_ID_DATA `` = 1'b1.
  - `` `ARB_LOCK_NONE/INST/DATA `` 2-bit encodings.
- One sub-module, `resp_id_fifo`: 1-bit-wide circular FIFO, depth `OUTSTANDING`.
  - Ports: `clk`, `reset`, `push`, `push_id`, `pop`, `head_id`, `count`, `full`, `empty`.
  - Same asynchronous reset.
- Top level holds the grant logic, lock register and muxing.
- Expected size about 200 lines total.

## Test plan
- **Single fetch:** `inst_req`=1, `inst_addr`=0x1c000000, `bus_addr_ok`=1 in cycle 0, `bus_data_ok`=1 with `bus_rdata`=0x12345678 in cycle 2 → `inst_addr_ok`=1 in cycle 0; `inst_data_ok`=1 and `inst_rdata`=0x12345678 in cycle 2; `data_data_ok`=0 throughout.
- **Priority:** both requests in cycle 0 with `data_addr`=0x80 and `bus_addr_ok`=1 → `bus_addr`=0x80 and `data_addr_ok`=1, `inst_addr_ok`=0; in cycle 1, INST is granted.
- **Lock:** `inst_req` in cycle 0, `bus_addr_ok`=0 for cycles 0–2, `data_req` rises in cycle 1 → `bus_addr`=`inst_addr` in cycles 0–3; `inst_addr_ok`=1 in cycle 3; DATA is granted in cycle 4.
- **Full and ordering** (`OUTSTANDING`=2): accept INST then DATA, then hold a third request → `bus_req`=0 until the first `bus_data_ok`. The first response raises only `inst_data_ok`; the second raises only `data_data_ok`; the third request is accepted the cycle after the first response.
- **Write:** `data_wr`=1, `data_size`=2, `data_wstrb`=4'hf, `data_wdata`=0xdeadbeef → `bus_*` carry identical values; the response raises `data_data_ok`.
- **Async reset mid-operation:** two requests outstanding, then `reset` pulsed between clock edges → all outputs take their reset values immediately and count=0. A subsequent stray `bus_data_ok` raises no `data_ok`, and a new fetch then completes normally.
